// File: rtl/regslv_reg_block_1.sv
// Register-block slave with seven 32-bit fields, each with a distinct software onwrite behaviour.
// Optional feature: define REGSLV_ACK_ERR_EN to add an ack_err output flagging unmapped accesses.
module regslv_reg_block_1 #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = 32'h0000_FFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_vld,
  output logic                  req_rdy,
  output logic                  ack_vld,
  input  logic                  ack_rdy,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
`ifdef REGSLV_ACK_ERR_EN
  output logic                  ack_err,
`endif
  input  logic                  global_sync_reset_in,
  output logic                  global_sync_reset_out,
  input  logic [DATA_WIDTH-1:0] REG1_ONWRITE_NA__FIELD_0__next_value,
  input  logic                  REG1_ONWRITE_NA__FIELD_0__pulse,
  output logic [DATA_WIDTH-1:0] REG1_ONWRITE_NA__FIELD_0__curr_value,
  input  logic [DATA_WIDTH-1:0] REG2_ONWRITE_WOCLR__FIELD_0__next_value,
  input  logic                  REG2_ONWRITE_WOCLR__FIELD_0__pulse,
  output logic [DATA_WIDTH-1:0] REG2_ONWRITE_WOCLR__FIELD_0__curr_value,
  input  logic [DATA_WIDTH-1:0] REG3_ONWRITE_WOSET__FIELD_0__next_value,
  input  logic                  REG3_ONWRITE_WOSET__FIELD_0__pulse,
  output logic [DATA_WIDTH-1:0] REG3_ONWRITE_WOSET__FIELD_0__curr_value,
  input  logic [DATA_WIDTH-1:0] REG4_ONWRITE_WOT__FIELD_0__next_value,
  input  logic                  REG4_ONWRITE_WOT__FIELD_0__pulse,
  output logic [DATA_WIDTH-1:0] REG4_ONWRITE_WOT__FIELD_0__curr_value,
  input  logic [DATA_WIDTH-1:0] REG5_ONWRITE_WZS__FIELD_0__next_value,
  input  logic                  REG5_ONWRITE_WZS__FIELD_0__pulse,
  output logic [DATA_WIDTH-1:0] REG5_ONWRITE_WZS__FIELD_0__curr_value,
  input  logic [DATA_WIDTH-1:0] REG6_ONWRITE_WZC__FIELD_0__next_value,
  input  logic                  REG6_ONWRITE_WZC__FIELD_0__pulse,
  output logic [DATA_WIDTH-1:0] REG6_ONWRITE_WZC__FIELD_0__curr_value,
  input  logic [DATA_WIDTH-1:0] REG7_ONWRITE_WZT__FIELD_0__next_value,
  input  logic                  REG7_ONWRITE_WZT__FIELD_0__pulse,
  output logic [DATA_WIDTH-1:0] REG7_ONWRITE_WZT__FIELD_0__curr_value
);

  localparam int NUM_REGS = 7;

  logic [DATA_WIDTH-1:0] field_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] hw_next [NUM_REGS];
  logic [NUM_REGS-1:0]   hw_pulse;
  logic [NUM_REGS-1:0]   hit;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  accept;
  logic                  sw_wr;
  logic                  sw_rd;

  assign hw_next[0] = REG1_ONWRITE_NA__FIELD_0__next_value;
  assign hw_next[1] = REG2_ONWRITE_WOCLR__FIELD_0__next_value;
  assign hw_next[2] = REG3_ONWRITE_WOSET__FIELD_0__next_value;
  assign hw_next[3] = REG4_ONWRITE_WOT__FIELD_0__next_value;
  assign hw_next[4] = REG5_ONWRITE_WZS__FIELD_0__next_value;
  assign hw_next[5] = REG6_ONWRITE_WZC__FIELD_0__next_value;
  assign hw_next[6] = REG7_ONWRITE_WZT__FIELD_0__next_value;

  assign hw_pulse = {REG7_ONWRITE_WZT__FIELD_0__pulse,
                     REG6_ONWRITE_WZC__FIELD_0__pulse,
                     REG5_ONWRITE_WZS__FIELD_0__pulse,
                     REG4_ONWRITE_WOT__FIELD_0__pulse,
                     REG3_ONWRITE_WOSET__FIELD_0__pulse,
                     REG2_ONWRITE_WOCLR__FIELD_0__pulse,
                     REG1_ONWRITE_NA__FIELD_0__pulse};

  assign REG1_ONWRITE_NA__FIELD_0__curr_value    = field_q[0];
  assign REG2_ONWRITE_WOCLR__FIELD_0__curr_value = field_q[1];
  assign REG3_ONWRITE_WOSET__FIELD_0__curr_value = field_q[2];
  assign REG4_ONWRITE_WOT__FIELD_0__curr_value   = field_q[3];
  assign REG5_ONWRITE_WZS__FIELD_0__curr_value   = field_q[4];
  assign REG6_ONWRITE_WZC__FIELD_0__curr_value   = field_q[5];
  assign REG7_ONWRITE_WZT__FIELD_0__curr_value   = field_q[6];

  assign global_sync_reset_out = global_sync_reset_in;

  // Single outstanding transaction: a pending ack blocks new requests.
  assign req_rdy = ~ack_vld;
  assign accept  = req_vld & req_rdy;
  assign sw_wr   = accept & wr_en;
  assign sw_rd   = accept & rd_en & ~wr_en;

  always_comb begin
    hit    = '0;
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      hit[i] = (addr == BASE_ADDR + ADDR_WIDTH'(4 * i));
      if (hit[i]) rd_mux = field_q[i];
    end
  end

  // Index selects the onwrite flavour: na, woclr, woset, wot, wzs, wzc, wzt.
  function automatic logic [DATA_WIDTH-1:0] sw_update(input int kind,
                                                      input logic [DATA_WIDTH-1:0] v,
                                                      input logic [DATA_WIDTH-1:0] d);
    case (kind)
      1:       return v & ~d;
      2:       return v | d;
      3:       return v ^ d;
      4:       return v | ~d;
      5:       return v & d;
      6:       return v ^ ~d;
      default: return v;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) field_q[i] <= RST_VAL;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (global_sync_reset_in)   field_q[i] <= RST_VAL;
        else if (sw_wr && hit[i])   field_q[i] <= sw_update(i, field_q[i], wr_data);
        else if (hw_pulse[i])       field_q[i] <= hw_next[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_vld <= 1'b0;
      rd_data <= '0;
    end else if (accept) begin
      ack_vld <= 1'b1;
      rd_data <= sw_rd ? rd_mux : '0;
    end else if (ack_vld && ack_rdy) begin
      ack_vld <= 1'b0;
    end
  end

`ifdef REGSLV_ACK_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ack_err <= 1'b0;
    else if (accept) ack_err <= ~(|hit);
  end
`endif

endmodule

// File: tb/tb_regslv_reg_block_1.sv
// Directed self-checking bench for regslv_reg_block_1; checks each onwrite flavour, hw pulses,
// back-pressure, unmapped access and the global synchronous reset.
module tb_regslv_reg_block_1;

  logic        clk;
  logic        rst;
  logic        req_vld;
  logic        req_rdy;
  logic        ack_vld;
  logic        ack_rdy;
  logic        wr_en;
  logic        rd_en;
  logic [63:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        global_sync_reset_in;
  logic        global_sync_reset_out;
  logic [31:0] hw_next [7];
  logic [6:0]  hw_pulse;
  logic [31:0] curr [7];
`ifdef REGSLV_ACK_ERR_EN
  logic        ack_err;
  logic        last_err;
`endif

  int checkCount = 0;
  int passCount  = 0;

  logic [31:0] expAfterZero [7] = '{32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF,
                                    32'hFFFFFFFF, 32'h00000000, 32'hFFFF0000};
  logic [31:0] expAfterOnes [7] = '{32'h0000FFFF, 32'h00000000, 32'hFFFFFFFF, 32'hFFFF0000,
                                    32'hFFFFFFFF, 32'h00000000, 32'hFFFF0000};

  regslv_reg_block_1 dut (
    .clk                                     (clk),
    .rst                                     (rst),
    .req_vld                                 (req_vld),
    .req_rdy                                 (req_rdy),
    .ack_vld                                 (ack_vld),
    .ack_rdy                                 (ack_rdy),
    .wr_en                                   (wr_en),
    .rd_en                                   (rd_en),
    .addr                                    (addr),
    .wr_data                                 (wr_data),
    .rd_data                                 (rd_data),
`ifdef REGSLV_ACK_ERR_EN
    .ack_err                                 (ack_err),
`endif
    .global_sync_reset_in                    (global_sync_reset_in),
    .global_sync_reset_out                   (global_sync_reset_out),
    .REG1_ONWRITE_NA__FIELD_0__next_value    (hw_next[0]),
    .REG1_ONWRITE_NA__FIELD_0__pulse         (hw_pulse[0]),
    .REG1_ONWRITE_NA__FIELD_0__curr_value    (curr[0]),
    .REG2_ONWRITE_WOCLR__FIELD_0__next_value (hw_next[1]),
    .REG2_ONWRITE_WOCLR__FIELD_0__pulse      (hw_pulse[1]),
    .REG2_ONWRITE_WOCLR__FIELD_0__curr_value (curr[1]),
    .REG3_ONWRITE_WOSET__FIELD_0__next_value (hw_next[2]),
    .REG3_ONWRITE_WOSET__FIELD_0__pulse      (hw_pulse[2]),
    .REG3_ONWRITE_WOSET__FIELD_0__curr_value (curr[2]),
    .REG4_ONWRITE_WOT__FIELD_0__next_value   (hw_next[3]),
    .REG4_ONWRITE_WOT__FIELD_0__pulse        (hw_pulse[3]),
    .REG4_ONWRITE_WOT__FIELD_0__curr_value   (curr[3]),
    .REG5_ONWRITE_WZS__FIELD_0__next_value   (hw_next[4]),
    .REG5_ONWRITE_WZS__FIELD_0__pulse        (hw_pulse[4]),
    .REG5_ONWRITE_WZS__FIELD_0__curr_value   (curr[4]),
    .REG6_ONWRITE_WZC__FIELD_0__next_value   (hw_next[5]),
    .REG6_ONWRITE_WZC__FIELD_0__pulse        (hw_pulse[5]),
    .REG6_ONWRITE_WZC__FIELD_0__curr_value   (curr[5]),
    .REG7_ONWRITE_WZT__FIELD_0__next_value   (hw_next[6]),
    .REG7_ONWRITE_WZT__FIELD_0__pulse        (hw_pulse[6]),
    .REG7_ONWRITE_WZT__FIELD_0__curr_value   (curr[6])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    else
      passCount++;
  endtask

  // Called at a falling edge; one accepted transaction, ack taken the cycle after it rises.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [63:0] a,
                               input logic [31:0] d, output logic [31:0] rdat);
    req_vld = 1'b1;
    wr_en   = wr;
    rd_en   = rd;
    addr    = a;
    wr_data = d;
    ack_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_vld = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    checkOutput("ack_vld_rise", {31'b0, ack_vld}, 32'h1);
    rdat = rd_data;
`ifdef REGSLV_ACK_ERR_EN
    last_err = ack_err;
`endif
    @(posedge clk);
    @(negedge clk);
    checkOutput("ack_vld_fall", {31'b0, ack_vld}, 32'h0);
  endtask

  logic [31:0] rdat;

  initial begin
    rst = 1'b1;
    req_vld = 1'b0;
    ack_rdy = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    addr = '0;
    wr_data = '0;
    global_sync_reset_in = 1'b0;
    hw_pulse = '0;
    for (int i = 0; i < 7; i++) hw_next[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    checkOutput("reset_ack_vld", {31'b0, ack_vld}, 32'h0);
    checkOutput("reset_rd_data", rd_data, 32'h0);
    checkOutput("reset_req_rdy", {31'b0, req_rdy}, 32'h1);
    for (int i = 0; i < 7; i++) checkOutput($sformatf("reset_reg%0d", i + 1), curr[i], 32'h0000FFFF);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b0, 64'(4 * i), 32'h00000000, rdat);
      checkOutput($sformatf("reg%0d_wr0", i + 1), curr[i], expAfterZero[i]);
      applyStimulus(1'b0, 1'b1, 64'(4 * i), 32'h0, rdat);
      checkOutput($sformatf("reg%0d_rd", i + 1), rdat, expAfterZero[i]);
      checkOutput($sformatf("reg%0d_rd_noside", i + 1), curr[i], expAfterZero[i]);
      applyStimulus(1'b1, 1'b0, 64'(4 * i), 32'hFFFFFFFF, rdat);
      checkOutput($sformatf("reg%0d_wr1_ackdata", i + 1), rdat, 32'h0);
      checkOutput($sformatf("reg%0d_wr1", i + 1), curr[i], expAfterOnes[i]);
    end

    hw_next[0]  = 32'h12345678;
    hw_pulse[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    hw_pulse[0] = 1'b0;
    checkOutput("reg1_hw_pulse", curr[0], 32'h12345678);

    applyStimulus(1'b0, 1'b1, 64'h1C, 32'h0, rdat);
    checkOutput("unmapped_rd", rdat, 32'h0);
`ifdef REGSLV_ACK_ERR_EN
    checkOutput("unmapped_err", {31'b0, last_err}, 32'h1);
    applyStimulus(1'b0, 1'b1, 64'h8, 32'h0, rdat);
    checkOutput("mapped_err", {31'b0, last_err}, 32'h0);
`endif

    // Back-pressure: hold the read ack of REG3 for three cycles.
    req_vld = 1'b1;
    rd_en   = 1'b1;
    addr    = 64'h8;
    ack_rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_vld = 1'b0;
    rd_en   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("hold%0d_ack_vld", k), {31'b0, ack_vld}, 32'h1);
      checkOutput($sformatf("hold%0d_rd_data", k), rd_data, 32'hFFFFFFFF);
      checkOutput($sformatf("hold%0d_req_rdy", k), {31'b0, req_rdy}, 32'h0);
      @(posedge clk);
      @(negedge clk);
    end
    ack_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("hold_release", {31'b0, ack_vld}, 32'h0);

    global_sync_reset_in = 1'b1;
    #1;
    checkOutput("gsr_out", {31'b0, global_sync_reset_out}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    global_sync_reset_in = 1'b0;
    for (int i = 0; i < 7; i++) checkOutput($sformatf("gsr_reg%0d", i + 1), curr[i], 32'h0000FFFF);

    // Same-edge sw woset write and hw pulse on REG3: 0000FFFF | 12340000.
    hw_next[2]  = 32'h00000000;
    hw_pulse[2] = 1'b1;
    req_vld = 1'b1;
    wr_en   = 1'b1;
    addr    = 64'h8;
    wr_data = 32'h12340000;
    @(posedge clk);
    @(negedge clk);
    hw_pulse[2] = 1'b0;
    req_vld = 1'b0;
    wr_en   = 1'b0;
    checkOutput("collide_reg3", curr[2], 32'h1234FFFF);
    @(posedge clk);
    @(negedge clk);

    // wr_en and rd_en together act as a write: wzc 0000FFFF & 0000FF00.
    applyStimulus(1'b1, 1'b1, 64'h10 + 64'h4, 32'h0000FF00, rdat);
    checkOutput("wr_rd_both_data", rdat, 32'h0);
    checkOutput("wr_rd_both_reg6", curr[5], 32'h0000FF00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
